// File: rtl/scoreboard_controller.sv
// -----------------------------------------------------------------------------
// scoreboard_controller
//
// Purpose:
//   Holds two two-digit BCD scores, one for player A and one for player B.
//   Count-up and count-down pulses come from the pushbutton processors. Only a
//   rising edge counts as a request; holding an input high adds nothing more.
//   Each player has a 1-deep pending slot. One shared BCD inc/dec unit serves
//   the slots, with round-robin arbitration when both are waiting. The block
//   also reports which player, if any, has reached WIN_SCORE.
//
// Optional feature:
//   SCOREBOARD_CLEAR_EN  when defined, adds clear_i. A rising edge on clear_i
//                        zeroes both scores and both slots. When undefined,
//                        there is no clear port and no clear logic.
//
// Parameters:
//   WIN_SCORE        binary score (1..99) that wins the game
//
// Ports:
//   clk_1khz         system clock, 1 kHz
//   rst_i            synchronous active-high reset
//   up_a_i/down_a_i  player A count-up / count-down pulses (multi-cycle high)
//   up_b_i/down_b_i  player B count-up / count-down pulses
//   clear_i          score clear request (SCOREBOARD_CLEAR_EN only)
//   score_a_*_o      player A tens / ones BCD digits
//   score_b_*_o      player B tens / ones BCD digits
//   winner_o         00 none, 01 player A, 10 player B
//   busy_o           high whenever the FSM is outside IDLE
//
// FSM states:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting; grants a pending slot (or a pending clear)
//   ST_CALC  | computes the next BCD value of the granted score
//   ST_WRITE | commits the result (or the clear) and re-evaluates winner_o
// -----------------------------------------------------------------------------
module scoreboard_controller #(
    parameter int unsigned WIN_SCORE = 21
) (
    input  logic       clk_1khz,
    input  logic       rst_i,
    input  logic       up_a_i,
    input  logic       down_a_i,
    input  logic       up_b_i,
    input  logic       down_b_i,
`ifdef SCOREBOARD_CLEAR_EN
    input  logic       clear_i,
`endif
    output logic [3:0] score_a_tens_o,
    output logic [3:0] score_a_ones_o,
    output logic [3:0] score_b_tens_o,
    output logic [3:0] score_b_ones_o,
    output logic [1:0] winner_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [6:0] WIN_VAL = 7'(WIN_SCORE);

    // Binary value of a two-digit BCD number. The widest result is 99, so
    // 7 bits are enough.
    function automatic logic [6:0] bcd_value(input logic [3:0] tens,
                                             input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

    state_t      state_q, state_d;

    // Previous request levels: [0] up_a, [1] down_a, [2] up_b, [3] down_b.
    logic [3:0]  edge_q, edge_d;
    logic [3:0]  rise;

    logic        slot_a_vld_q, slot_a_vld_d;
    logic        slot_a_up_q,  slot_a_up_d;
    logic        slot_b_vld_q, slot_b_vld_d;
    logic        slot_b_up_q,  slot_b_up_d;

    // 1 = player B received the most recent grant.
    logic        last_b_q, last_b_d;
    logic        gnt_b_q,  gnt_b_d;
    logic        gnt_up_q, gnt_up_d;

    logic [3:0]  res_tens_q, res_tens_d;
    logic [3:0]  res_ones_q, res_ones_d;

    logic [3:0]  a_tens_q, a_tens_d;
    logic [3:0]  a_ones_q, a_ones_d;
    logic [3:0]  b_tens_q, b_tens_d;
    logic [3:0]  b_ones_q, b_ones_d;
    logic [1:0]  winner_q, winner_d;

`ifdef SCOREBOARD_CLEAR_EN
    logic        clr_prev_q, clr_prev_d;
    logic        clr_pend_q, clr_pend_d;
    logic        op_clr_q,   op_clr_d;
`endif

    // Combinational helpers for the IDLE grant and the CALC step.
    logic        take_a;
    logic        take_b;
    logic        flush;
    logic        pick_b;
    logic        pick_up;
    logic [3:0]  cur_tens;
    logic [3:0]  cur_ones;

    assign rise = {down_b_i, up_b_i, down_a_i, up_a_i} & ~edge_q;

    always_comb begin
        state_d      = state_q;
        edge_d       = {down_b_i, up_b_i, down_a_i, up_a_i};
        slot_a_vld_d = slot_a_vld_q;
        slot_a_up_d  = slot_a_up_q;
        slot_b_vld_d = slot_b_vld_q;
        slot_b_up_d  = slot_b_up_q;
        last_b_d     = last_b_q;
        gnt_b_d      = gnt_b_q;
        gnt_up_d     = gnt_up_q;
        res_tens_d   = res_tens_q;
        res_ones_d   = res_ones_q;
        a_tens_d     = a_tens_q;
        a_ones_d     = a_ones_q;
        b_tens_d     = b_tens_q;
        b_ones_d     = b_ones_q;
        winner_d     = winner_q;
        take_a       = 1'b0;
        take_b       = 1'b0;
        flush        = 1'b0;
        pick_b       = 1'b0;
        pick_up      = 1'b0;
        cur_tens     = gnt_b_q ? b_tens_q : a_tens_q;
        cur_ones     = gnt_b_q ? b_ones_q : a_ones_q;
`ifdef SCOREBOARD_CLEAR_EN
        clr_prev_d   = clear_i;
        clr_pend_d   = clr_pend_q;
        op_clr_d     = op_clr_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
`ifdef SCOREBOARD_CLEAR_EN
                if (clr_pend_q) begin
                    // A clear beats both player slots and needs no CALC.
                    clr_pend_d = 1'b0;
                    op_clr_d   = 1'b1;
                    state_d    = ST_WRITE;
                end else
`endif
                if (slot_a_vld_q || slot_b_vld_q) begin
                    // When both slots wait, the player not granted last wins.
                    pick_b   = slot_b_vld_q && (!slot_a_vld_q || !last_b_q);
                    pick_up  = pick_b ? slot_b_up_q : slot_a_up_q;
                    take_a   = !pick_b;
                    take_b   = pick_b;
                    last_b_d = pick_b;
                    // Once a winner exists, up requests are swallowed here.
                    // Down requests still go through so a correction can
                    // revoke the win.
                    if (!(pick_up && (winner_q != 2'b00))) begin
                        gnt_b_d  = pick_b;
                        gnt_up_d = pick_up;
                        state_d  = ST_CALC;
`ifdef SCOREBOARD_CLEAR_EN
                        op_clr_d = 1'b0;
`endif
                    end
                end
            end

            ST_CALC: begin
                res_tens_d = cur_tens;
                res_ones_d = cur_ones;
                if (gnt_up_q) begin
                    if (!(cur_tens == 4'd9 && cur_ones == 4'd9)) begin
                        if (cur_ones == 4'd9) begin
                            res_ones_d = 4'd0;
                            res_tens_d = cur_tens + 4'd1;
                        end else begin
                            res_ones_d = cur_ones + 4'd1;
                        end
                    end
                end else begin
                    if (!(cur_tens == 4'd0 && cur_ones == 4'd0)) begin
                        if (cur_ones == 4'd0) begin
                            res_ones_d = 4'd9;
                            res_tens_d = cur_tens - 4'd1;
                        end else begin
                            res_ones_d = cur_ones - 4'd1;
                        end
                    end
                end
                state_d = ST_WRITE;
            end

            ST_WRITE: begin
`ifdef SCOREBOARD_CLEAR_EN
                if (op_clr_q) begin
                    a_tens_d = 4'd0;
                    a_ones_d = 4'd0;
                    b_tens_d = 4'd0;
                    b_ones_d = 4'd0;
                    flush    = 1'b1;
                end else
`endif
                if (gnt_b_q) begin
                    b_tens_d = res_tens_q;
                    b_ones_d = res_ones_q;
                end else begin
                    a_tens_d = res_tens_q;
                    a_ones_d = res_ones_q;
                end
                // Evaluated on the scores being written, so winner_o changes
                // on the same edge as the score.
                if (bcd_value(a_tens_d, a_ones_d) >= WIN_VAL) begin
                    winner_d = 2'b01;
                end else if (bcd_value(b_tens_d, b_ones_d) >= WIN_VAL) begin
                    winner_d = 2'b10;
                end else begin
                    winner_d = 2'b00;
                end
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // Slot capture. Up and down rising together cancel. An edge is dropped
        // when the slot is already full, and also on the edge where the slot
        // is being granted or flushed.
        if (take_a || flush) begin
            slot_a_vld_d = 1'b0;
        end else if (!slot_a_vld_q && (rise[0] ^ rise[1])) begin
            slot_a_vld_d = 1'b1;
            slot_a_up_d  = rise[0];
        end

        if (take_b || flush) begin
            slot_b_vld_d = 1'b0;
        end else if (!slot_b_vld_q && (rise[2] ^ rise[3])) begin
            slot_b_vld_d = 1'b1;
            slot_b_up_d  = rise[2];
        end

`ifdef SCOREBOARD_CLEAR_EN
        // A new clear edge wins over the consume in IDLE, so it is never lost.
        if (clear_i && !clr_prev_q) begin
            clr_pend_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_1khz) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            edge_q       <= 4'b0000;
            slot_a_vld_q <= 1'b0;
            slot_a_up_q  <= 1'b0;
            slot_b_vld_q <= 1'b0;
            slot_b_up_q  <= 1'b0;
            last_b_q     <= 1'b1;
            gnt_b_q      <= 1'b0;
            gnt_up_q     <= 1'b0;
            res_tens_q   <= 4'd0;
            res_ones_q   <= 4'd0;
            a_tens_q     <= 4'd0;
            a_ones_q     <= 4'd0;
            b_tens_q     <= 4'd0;
            b_ones_q     <= 4'd0;
            winner_q     <= 2'b00;
`ifdef SCOREBOARD_CLEAR_EN
            clr_prev_q   <= 1'b0;
            clr_pend_q   <= 1'b0;
            op_clr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            edge_q       <= edge_d;
            slot_a_vld_q <= slot_a_vld_d;
            slot_a_up_q  <= slot_a_up_d;
            slot_b_vld_q <= slot_b_vld_d;
            slot_b_up_q  <= slot_b_up_d;
            last_b_q     <= last_b_d;
            gnt_b_q      <= gnt_b_d;
            gnt_up_q     <= gnt_up_d;
            res_tens_q   <= res_tens_d;
            res_ones_q   <= res_ones_d;
            a_tens_q     <= a_tens_d;
            a_ones_q     <= a_ones_d;
            b_tens_q     <= b_tens_d;
            b_ones_q     <= b_ones_d;
            winner_q     <= winner_d;
`ifdef SCOREBOARD_CLEAR_EN
            clr_prev_q   <= clr_prev_d;
            clr_pend_q   <= clr_pend_d;
            op_clr_q     <= op_clr_d;
`endif
        end
    end

    assign score_a_tens_o = a_tens_q;
    assign score_a_ones_o = a_ones_q;
    assign score_b_tens_o = b_tens_q;
    assign score_b_ones_o = b_ones_q;
    assign winner_o       = winner_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scoreboard_controller.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_controller
//
// Directed self-checking bench for scoreboard_controller with the default
// WIN_SCORE of 21. Stimulus changes on the falling clock edge and outputs are
// sampled on the falling edge. If N0 is the falling edge where a request goes
// high, then the rising edge right after N0 is E0, and a score written at E3
// is first visible at N4.
// -----------------------------------------------------------------------------
module tb_scoreboard_controller;

    logic       clk_1khz = 1'b0;
    logic       rst_i    = 1'b1;
    logic       up_a     = 1'b0;
    logic       down_a   = 1'b0;
    logic       up_b     = 1'b0;
    logic       down_b   = 1'b0;
`ifdef SCOREBOARD_CLEAR_EN
    logic       clear_i  = 1'b0;
`endif
    logic [3:0] a_tens, a_ones, b_tens, b_ones;
    logic [1:0] winner;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk_1khz = ~clk_1khz;

    scoreboard_controller #(.WIN_SCORE(21)) dut (
        .clk_1khz       (clk_1khz),
        .rst_i          (rst_i),
        .up_a_i         (up_a),
        .down_a_i       (down_a),
        .up_b_i         (up_b),
        .down_b_i       (down_b),
`ifdef SCOREBOARD_CLEAR_EN
        .clear_i        (clear_i),
`endif
        .score_a_tens_o (a_tens),
        .score_a_ones_o (a_ones),
        .score_b_tens_o (b_tens),
        .score_b_ones_o (b_ones),
        .winner_o       (winner),
        .busy_o         (busy)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_1khz);
    endtask

    // which: 0 up_a, 1 down_a, 2 up_b, 3 down_b
    task automatic set_req(input int which, input logic v);
        case (which)
            0: up_a   = v;
            1: down_a = v;
            2: up_b   = v;
            default: down_b = v;
        endcase
    endtask

    // One request pulse. Returns at N4, where the write is already visible.
    task automatic press(input int which);
        set_req(which, 1'b1);
        cyc(1);
        set_req(which, 1'b0);
        cyc(3);
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        up_a = 1'b0; down_a = 1'b0; up_b = 1'b0; down_b = 1'b0;
`ifdef SCOREBOARD_CLEAR_EN
        clear_i = 1'b0;
`endif
        cyc(2);
        rst_i = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({a_tens, a_ones} !== 8'h00) begin
            errors++; $display("FAIL reset_a got %h exp 00", {a_tens, a_ones});
        end
        checks++;
        if ({b_tens, b_ones} !== 8'h00) begin
            errors++; $display("FAIL reset_b got %h exp 00", {b_tens, b_ones});
        end
        checks++;
        if (winner !== 2'b00) begin
            errors++; $display("FAIL reset_winner got %b exp 00", winner);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_single_up;
        do_reset();
        up_a = 1'b1;                       // N0
        cyc(1);                            // N1: slot set, not yet granted
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_busy_n1 got %b exp 0", busy);
        end
        cyc(1);                            // N2: CALC
        checks++;
        if (busy !== 1'b1 || {a_tens, a_ones} !== 8'h00) begin
            errors++; $display("FAIL single_n2 busy %b a %h exp busy 1 a 00", busy, {a_tens, a_ones});
        end
        cyc(1);                            // N3: WRITE
        checks++;
        if (busy !== 1'b1 || {a_tens, a_ones} !== 8'h00) begin
            errors++; $display("FAIL single_n3 busy %b a %h exp busy 1 a 00", busy, {a_tens, a_ones});
        end
        cyc(1);                            // N4: written
        checks++;
        if (busy !== 1'b0 || {a_tens, a_ones} !== 8'h01) begin
            errors++; $display("FAIL single_n4 busy %b a %h exp busy 0 a 01", busy, {a_tens, a_ones});
        end
        cyc(7);                            // input still high through N11
        checks++;
        if ({a_tens, a_ones} !== 8'h01 || busy !== 1'b0) begin
            errors++; $display("FAIL single_hold a %h busy %b exp a 01 busy 0", {a_tens, a_ones}, busy);
        end
        up_a = 1'b0;
        cyc(2);
    endtask

    task automatic test_simultaneous;
        do_reset();
        repeat (5) press(2);               // B = 05, last grant B
        checks++;
        if ({b_tens, b_ones} !== 8'h05) begin
            errors++; $display("FAIL simul_preload_b got %h exp 05", {b_tens, b_ones});
        end
        up_a = 1'b1; down_b = 1'b1;        // tie at N0
        cyc(1);
        up_a = 1'b0; down_b = 1'b0;
        cyc(3);                            // N4
        checks++;
        if ({a_tens, a_ones} !== 8'h01 || {b_tens, b_ones} !== 8'h05) begin
            errors++; $display("FAIL simul_first a %h b %h exp a 01 b 05", {a_tens, a_ones}, {b_tens, b_ones});
        end
        cyc(2);                            // N6
        checks++;
        if ({b_tens, b_ones} !== 8'h05) begin
            errors++; $display("FAIL simul_b_early got %h exp 05", {b_tens, b_ones});
        end
        cyc(1);                            // N7
        checks++;
        if ({b_tens, b_ones} !== 8'h04) begin
            errors++; $display("FAIL simul_second_b got %h exp 04", {b_tens, b_ones});
        end
        press(0);                          // A = 02, last grant A
        up_a = 1'b1; up_b = 1'b1;          // next tie goes to B
        cyc(1);
        up_a = 1'b0; up_b = 1'b0;
        cyc(3);                            // N4
        checks++;
        if ({b_tens, b_ones} !== 8'h05 || {a_tens, a_ones} !== 8'h02) begin
            errors++; $display("FAIL tie2_first a %h b %h exp a 02 b 05", {a_tens, a_ones}, {b_tens, b_ones});
        end
        cyc(3);                            // N7
        checks++;
        if ({a_tens, a_ones} !== 8'h03) begin
            errors++; $display("FAIL tie2_second_a got %h exp 03", {a_tens, a_ones});
        end
    endtask

    task automatic test_wrap_saturate;
        do_reset();
        repeat (9) press(0);
        checks++;
        if ({a_tens, a_ones} !== 8'h09) begin
            errors++; $display("FAIL wrap_09 got %h exp 09", {a_tens, a_ones});
        end
        press(0);
        checks++;
        if ({a_tens, a_ones} !== 8'h10) begin
            errors++; $display("FAIL wrap_up_10 got %h exp 10", {a_tens, a_ones});
        end
        press(1);
        checks++;
        if ({a_tens, a_ones} !== 8'h09) begin
            errors++; $display("FAIL wrap_down_09 got %h exp 09", {a_tens, a_ones});
        end
        down_b = 1'b1;
        cyc(2);                            // N2: saturated request still uses CALC
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL sat_busy got %b exp 1", busy);
        end
        down_b = 1'b0;
        cyc(2);
        checks++;
        if ({b_tens, b_ones} !== 8'h00) begin
            errors++; $display("FAIL sat_down_b got %h exp 00", {b_tens, b_ones});
        end
    endtask

    task automatic test_winner;
        do_reset();
        repeat (20) press(0);
        checks++;
        if ({a_tens, a_ones} !== 8'h20 || winner !== 2'b00) begin
            errors++; $display("FAIL win_pre a %h w %b exp a 20 w 00", {a_tens, a_ones}, winner);
        end
        press(0);
        checks++;
        if ({a_tens, a_ones} !== 8'h21 || winner !== 2'b01) begin
            errors++; $display("FAIL win_set a %h w %b exp a 21 w 01", {a_tens, a_ones}, winner);
        end
        up_a = 1'b1;
        cyc(2);                            // N2: discarded in IDLE, never busy
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL win_discard_busy got %b exp 0", busy);
        end
        up_a = 1'b0;
        cyc(2);
        checks++;
        if ({a_tens, a_ones} !== 8'h21) begin
            errors++; $display("FAIL win_hold a got %h exp 21", {a_tens, a_ones});
        end
        press(1);
        checks++;
        if ({a_tens, a_ones} !== 8'h20 || winner !== 2'b00) begin
            errors++; $display("FAIL win_revoke a %h w %b exp a 20 w 00", {a_tens, a_ones}, winner);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        up_a = 1'b1;                       // N0
        cyc(1);
        up_a = 1'b0;                       // N1
        cyc(1);
        up_a = 1'b1;                       // N2: rises during CALC
        cyc(1);
        up_a = 1'b0;
        cyc(1);                            // N4
        checks++;
        if ({a_tens, a_ones} !== 8'h01) begin
            errors++; $display("FAIL b2b_first got %h exp 01", {a_tens, a_ones});
        end
        cyc(3);                            // N7
        checks++;
        if ({a_tens, a_ones} !== 8'h02) begin
            errors++; $display("FAIL b2b_second got %h exp 02", {a_tens, a_ones});
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        repeat (3) press(0);               // A = 03
        up_a = 1'b1;                       // N0
        cyc(1);
        up_a = 1'b0;
        cyc(1);                            // N2
        rst_i = 1'b1;                      // sampled at E2
        cyc(1);                            // N3
        checks++;
        if ({a_tens, a_ones} !== 8'h00 || busy !== 1'b0 || winner !== 2'b00) begin
            errors++; $display("FAIL rstmid a %h busy %b w %b exp 00 0 00", {a_tens, a_ones}, busy, winner);
        end
        rst_i = 1'b0;
        cyc(6);
        checks++;
        if ({a_tens, a_ones} !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_late a %h busy %b exp 00 0", {a_tens, a_ones}, busy);
        end
    endtask

`ifdef SCOREBOARD_CLEAR_EN
    task automatic test_clear;
        do_reset();
        repeat (7) press(0);
        repeat (12) press(2);
        checks++;
        if ({a_tens, a_ones} !== 8'h07 || {b_tens, b_ones} !== 8'h12) begin
            errors++; $display("FAIL clr_pre a %h b %h exp 07 12", {a_tens, a_ones}, {b_tens, b_ones});
        end
        up_b = 1'b1; clear_i = 1'b1;       // N0
        cyc(1);
        up_b = 1'b0; clear_i = 1'b0;
        cyc(2);                            // N3: clear written at E2
        checks++;
        if ({a_tens, a_ones, b_tens, b_ones} !== 16'h0000 || winner !== 2'b00) begin
            errors++; $display("FAIL clr_done scores %h w %b exp 0000 00", {a_tens, a_ones, b_tens, b_ones}, winner);
        end
        cyc(6);
        checks++;
        if ({b_tens, b_ones} !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL clr_pending_dropped b %h busy %b exp 00 0", {b_tens, b_ones}, busy);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_up();
        test_simultaneous();
        test_wrap_saturate();
        test_winner();
        test_back_to_back();
        test_reset_mid();
`ifdef SCOREBOARD_CLEAR_EN
        test_clear();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
